// File: rtl/uart_pkg.sv
// Shared UART framing definitions, used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int DIV_W_DEF     = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs, with a selectable reset value.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register behind a valid/ready handshake.
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | timing to mid start bit to confirm it is not a glitch
// RX_DATA  | sampling data bits at bit-period intervals, LSB first
// RX_STOP  | sampling the stop bit, then back to idle at mid stop bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int DIV_W     = DIV_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic [DIV_W-1:0]     clks_per_bit_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_e            state_q, state_d;
  logic                 rx_s, rx_prev_q;
  logic [DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 start_edge, mid_start, bit_end, last_bit;
  logic                 sample_bit, stop_ok, stop_bad;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  assign start_edge = rx_prev_q & ~rx_s;
  assign mid_start  = (cnt_q == ((div_q >> 1) - DIV_W'(1)));
  assign bit_end    = (cnt_q == (div_q - DIV_W'(1)));
  assign last_bit   = (bit_cnt_q == BC_W'(DATA_BITS - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE:  if (start_edge) state_d = RX_START;
        RX_START: if (mid_start)  state_d = rx_s ? RX_IDLE : RX_DATA;
        RX_DATA:  if (bit_end && last_bit) state_d = RX_STOP;
        RX_STOP:  if (bit_end)    state_d = RX_IDLE;
        default:  state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o     = (state_q != RX_IDLE);
    sample_bit = en_i && (state_q == RX_DATA) && bit_end;
    stop_ok    = en_i && (state_q == RX_STOP) && bit_end && rx_s;
    stop_bad   = en_i && (state_q == RX_STOP) && bit_end && !rx_s;
  end

  always_comb begin
    // Baud counter restarts on every state change and on every data-bit sample.
    if (state_q == RX_IDLE || state_d != state_q || sample_bit) cnt_d = '0;
    else                                                         cnt_d = cnt_q + DIV_W'(1);

    bit_cnt_d = bit_cnt_q;
    if (state_q == RX_START)          bit_cnt_d = '0;
    else if (sample_bit && !last_bit) bit_cnt_d = bit_cnt_q + BC_W'(1);

    shift_d = sample_bit ? {rx_s, shift_q[DATA_BITS-1:1]} : shift_q;
    div_d   = (state_q == RX_IDLE && en_i && start_edge) ? clks_per_bit_i : div_q;

    data_d  = data_q;
    valid_d = valid_q;
    if (stop_ok && (!valid_q || ready_i)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    frame_err_d = stop_bad;
    overrun_d   = stop_ok && valid_q && !ready_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      div_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_prev_q   <= rx_s;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: drives serial frames and checks against a frame-level model
// of the holding register, handshakes and error pulses.
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        en_i;
  logic [15:0] clks_per_bit_i;
  logic        rx_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        frame_err_o;
  logic        overrun_o;

  uart_rx dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .en_i           (en_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_i           (rx_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .busy_o         (busy_o),
    .frame_err_o    (frame_err_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // monitor state
  int         cyc = 0;
  int         rise_cyc = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         busy_cnt = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];

  // frame-level reference model
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         exp_ferr = 0;
  int         exp_ovr = 0;
  logic [7:0] exp_q[$];
  int         t0 = 0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (rstn_i === 1'b1) begin
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (frame_err_o) n_ferr++;
      if (overrun_o) n_ovr++;
      if (busy_o) busy_cnt++;
      if (valid_o && !valid_prev) rise_cyc = cyc;
    end
    valid_prev = valid_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v, input int div);
    rx_i = v;
    repeat (div) @(posedge clk_i);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic stop_v, input logic r,
                           input int div, input int gap);
    ready_i        = r;
    clks_per_bit_i = 16'(div);
    if (r && m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
    t0 = cyc;
    drive_bit(1'b0, div);
    clks_per_bit_i = 16'($urandom_range(4, 40));
    for (int i = 0; i < 8; i++) drive_bit(b[i], div);
    drive_bit(stop_v, div);
    rx_i = 1'b1;
    if (!stop_v) begin
      exp_ferr++;
    end else if (!m_valid) begin
      m_data = b;
      if (r) exp_q.push_back(b);
      else   m_valid = 1'b1;
    end else begin
      exp_ovr++;
    end
    repeat (gap) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_ready();
    ready_i = 1'b1;
    if (m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_valid"}, 32'(valid_o), 32'(m_valid));
    check_eq({tag, "_data"}, 32'(data_o), 32'(m_data));
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_ferr_cycles"}, n_ferr, exp_ferr);
    check_eq({tag, "_ovr_cycles"}, n_ovr, exp_ovr);
    check_eq({tag, "_hs_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_hs_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int b0;
    logic [7:0] rb;
    int rdiv, rgap;
    logic rstop, rr;

    rstn_i = 1'b0;
    en_i = 1'b1;
    ready_i = 1'b0;
    rx_i = 1'b1;
    clks_per_bit_i = 16'd8;
    repeat (3) @(posedge clk_i);
    #2;
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_ferr", 32'(frame_err_o), 32'd0);
    check_eq("rst_ovr", 32'(overrun_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (4) @(posedge clk_i);
    #1;
    check_state("idle");

    run_frame(8'h55, 1'b1, 1'b0, 8, 2);
    check_eq("latency_55", rise_cyc - t0, 79);
    check_state("f55");
    pulse_ready();
    check_state("read55");

    run_frame(8'hA5, 1'b1, 1'b1, 8, 0);
    run_frame(8'h3C, 1'b1, 1'b1, 8, 3);
    check_state("b2b");

    run_frame(8'h12, 1'b0, 1'b0, 8, 3);
    check_state("stop_low");

    run_frame(8'h01, 1'b1, 1'b0, 8, 2);
    run_frame(8'h02, 1'b1, 1'b0, 8, 2);
    check_state("overrun");
    pulse_ready();
    check_state("overrun_read");

    clks_per_bit_i = 16'd8;
    b0 = busy_cnt;
    rx_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check_eq("glitch_busy_1_to_6", 32'((busy_cnt - b0) >= 1 && (busy_cnt - b0) <= 6), 32'd1);
    check_state("glitch");

    for (int k = 0; k < 40; k++) begin
      rb    = 8'($urandom);
      rdiv  = $urandom_range(4, 12);
      rstop = ($urandom_range(0, 7) != 0);
      rr    = 1'($urandom_range(0, 1));
      rgap  = $urandom_range(2, 4);
      run_frame(rb, rstop, rr, rdiv, rgap);
      check_state("rand");
    end

    run_frame(8'h5A, 1'b1, 1'b0, 8, 2);
    check_state("pre_abort");
    clks_per_bit_i = 16'd8;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    check_eq("abort_busy_before", 32'(busy_o), 32'd1);
    en_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("abort_busy_after", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    repeat (16) @(posedge clk_i);
    #1;
    en_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check_state("abort");

    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    #2;
    rstn_i = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(valid_o), 32'd0);
    check_eq("midrst_data", 32'(data_o), 32'd0);
    check_eq("midrst_busy", 32'(busy_o), 32'd0);
    check_eq("midrst_ferr", 32'(frame_err_o), 32'd0);
    check_eq("midrst_ovr", 32'(overrun_o), 32'd0);
    rx_i = 1'b1;
    m_valid = 1'b0;
    m_data = 8'h00;
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (3) @(posedge clk_i);
    #1;
    run_frame(8'hC3, 1'b1, 1'b0, 8, 2);
    check_state("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
